// File: rtl/neural_stage_ctrl.sv
// Sequencing controller for a pipelined neural_stage: counts taps and vectors of a batch,
// tracks samples through the datapath latency and aligns bias addressing with its output.
module neural_stage_ctrl #(
    parameter int unsigned TAPS    = 16,
    parameter int unsigned LATENCY = 18,
    parameter int unsigned VEC_W   = 16,
    localparam int unsigned TAP_W  = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VEC_W-1:0] num_vectors,
    input  logic             error_mode_cfg,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             first,
    output logic             error_mode,
    output logic             error_first,
    output logic [TAP_W-1:0] tap_index,
    output logic [VEC_W-1:0] bias_addr,
    output logic             bias_valid,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
    logic [VEC_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [VEC_W-1:0]   num_q, num_d;
    logic               err_mode_q, err_mode_d;
    logic [VEC_W-1:0]   bias_cnt_q, bias_cnt_d;
    logic [LATENCY-1:0] acc_sr_q, acc_sr_d;
    logic [LATENCY-1:0] fst_sr_q, fst_sr_d;

    logic accept_c;
    logic first_c;
    logic last_tap_c;
    logic last_vec_c;

    assign accept_c   = in_valid && (state_q == S_RUN);
    assign first_c    = accept_c && (tap_cnt_q == '0);
    assign last_tap_c = (tap_cnt_q == TAP_W'(TAPS - 1));
    assign last_vec_c = (vec_cnt_q == (num_q - VEC_W'(1)));

    // Delay line mirroring the datapath: one {accept, first} pair enters per cycle.
    if (LATENCY > 1) begin : g_sr_deep
        always_comb begin
            acc_sr_d = {acc_sr_q[LATENCY-2:0], accept_c};
            fst_sr_d = {fst_sr_q[LATENCY-2:0], first_c};
        end
    end else begin : g_sr_single
        always_comb begin
            acc_sr_d = accept_c;
            fst_sr_d = first_c;
        end
    end

    always_comb begin
        state_d    = state_q;
        tap_cnt_d  = tap_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        num_d      = num_q;
        err_mode_d = err_mode_q;
        bias_cnt_d = bias_cnt_q;

        if (bias_valid) begin
            bias_cnt_d = bias_cnt_q + VEC_W'(1);
        end

        if (accept_c) begin
            tap_cnt_d = tap_cnt_q + TAP_W'(1);
            if (last_tap_c) begin
                vec_cnt_d = vec_cnt_q + VEC_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_mode_d = error_mode_cfg;
                    if (num_vectors != '0) begin
                        state_d    = S_RUN;
                        num_d      = num_vectors;
                        tap_cnt_d  = '0;
                        vec_cnt_d  = '0;
                        bias_cnt_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // Completion is caught at count-1, so vec_cnt never wraps.
                if (accept_c && last_tap_c && last_vec_c) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!(|acc_sr_d)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tap_cnt_q  <= '0;
            vec_cnt_q  <= '0;
            num_q      <= '0;
            err_mode_q <= 1'b0;
            bias_cnt_q <= '0;
            acc_sr_q   <= '0;
            fst_sr_q   <= '0;
        end else begin
            state_q    <= state_d;
            tap_cnt_q  <= tap_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            num_q      <= num_d;
            err_mode_q <= err_mode_d;
            bias_cnt_q <= bias_cnt_d;
            acc_sr_q   <= acc_sr_d;
            fst_sr_q   <= fst_sr_d;
        end
    end

    assign in_ready    = (state_q == S_RUN);
    assign first       = first_c;
    assign error_mode  = err_mode_q;
    assign error_first = first_c && err_mode_q;
    assign tap_index   = tap_cnt_q;
    assign bias_addr   = bias_cnt_q;
    assign bias_valid  = fst_sr_q[LATENCY-1];
    assign out_valid   = acc_sr_q[LATENCY-1];
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_neural_stage_ctrl.sv
// Self-checking bench for neural_stage_ctrl: directed vector table, hand sequences,
// and randomized batches checked against an accept-list model.
module tb_neural_stage_ctrl;

    localparam int T    = 16;
    localparam int L    = 18;
    localparam int VW   = 16;
    localparam int TW   = $clog2(T);
    localparam int MAXC = 500;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [VW-1:0] num_vectors;
    logic          error_mode_cfg;
    logic          in_valid;
    logic          in_ready;
    logic          first;
    logic          error_mode;
    logic          error_first;
    logic [TW-1:0] tap_index;
    logic [VW-1:0] bias_addr;
    logic          bias_valid;
    logic          out_valid;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;
    int ba_prev = 0;
    bit em_prev = 1'b0;

    bit iv_a [0:MAXC];
    int acc_a[0:MAXC];

    typedef struct {
        bit rst_n;
        bit st;
        int nv;
        bit cfg;
        bit iv;
        bit rdy;
        bit bsy;
        bit dn;
        bit em;
        bit fst;
        int tap;
    } vec_t;

    vec_t tbl[14];

    neural_stage_ctrl #(.TAPS(T), .LATENCY(L), .VEC_W(VW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_vectors   (num_vectors),
        .error_mode_cfg(error_mode_cfg),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .first         (first),
        .error_mode    (error_mode),
        .error_first   (error_first),
        .tap_index     (tap_index),
        .bias_addr     (bias_addr),
        .bias_valid    (bias_valid),
        .out_valid     (out_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit st, int nv, bit cfg, bit iv,
                                bit rdy, bit bsy, bit dn, bit em, bit fst, int tap);
        vec_t v;
        v.rst_n = r; v.st = st; v.nv = nv; v.cfg = cfg; v.iv = iv;
        v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.em = em; v.fst = fst; v.tap = tap;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input bit rdy, input bit bsy, input bit dn,
                           input bit em, input bit fst, input bit ov, input bit bv,
                           input int tap, input int ba);
        chk({tag, ".in_ready"},    32'(in_ready),    32'(rdy));
        chk({tag, ".busy"},        32'(busy),        32'(bsy));
        chk({tag, ".done"},        32'(done),        32'(dn));
        chk({tag, ".error_mode"},  32'(error_mode),  32'(em));
        chk({tag, ".first"},       32'(first),       32'(fst));
        chk({tag, ".error_first"}, 32'(error_first), 32'(fst && em));
        chk({tag, ".tap_index"},   32'(tap_index),   32'(tap));
        chk({tag, ".out_valid"},   32'(out_valid),   32'(ov));
        chk({tag, ".bias_valid"},  32'(bias_valid),  32'(bv));
        chk({tag, ".bias_addr"},   32'(bias_addr),   32'(ba));
    endtask

    task automatic drive(input bit r, input bit st, input int nv, input bit cfg, input bit iv);
        reset          = r;
        start          = st;
        num_vectors    = VW'(nv);
        error_mode_cfg = cfg;
        in_valid       = iv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random in_valid, 1: low every 3rd cycle, 2: always high
    task automatic run_batch(input int n, input bit e, input int mode);
        int total, cnt, a_last, d, cb, nb;
        bit fst, ov, bv;
        total = n * T; cnt = 0; a_last = 0;
        for (int c = 0; c <= MAXC; c++) begin
            if (mode == 2 || c >= 300)  iv_a[c] = 1'b1;
            else if (mode == 1)         iv_a[c] = (c % 3) != 2;
            else                        iv_a[c] = ($urandom_range(0, 3) != 0);
            acc_a[c] = -1;
            if (c >= 1 && cnt < total && iv_a[c]) begin
                acc_a[c] = cnt;
                cnt++;
                if (cnt == total) a_last = c;
            end
        end
        d = a_last + L + 1;
        cb = 0; nb = 0;
        for (int c = 0; c <= d + 1; c++) begin
            if (c == 0) drive(1'b1, 1'b1, n, e, iv_a[c]);
            else drive(1'b1, (c <= d) && ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), iv_a[c]);
            #4;
            fst = (acc_a[c] >= 0) && ((acc_a[c] % T) == 0);
            ov  = (c > L) && (acc_a[c-L] >= 0);
            bv  = ov && ((acc_a[c-L] % T) == 0);
            chk_out($sformatf("batch_n%0d_c%0d", n, c), (c >= 1) && (c <= a_last),
                    (c >= 1) && (c <= d), c == d, (c == 0) ? em_prev : e,
                    fst, ov, bv, cb % T, (c == 0) ? ba_prev : nb);
            if (acc_a[c] >= 0) cb++;
            if (bv) nb++;
            tick();
        end
        ba_prev = n;
        em_prev = e;
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 1,  1, 1, 0, 1, 1, 0);
        tbl[6]  = mk(1, 1, 5, 0, 1,  1, 1, 0, 1, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 2);
        tbl[8]  = mk(1, 1, 3, 0, 1,  1, 1, 0, 1, 0, 2);
        tbl[9]  = mk(0, 0, 0, 0, 1,  1, 1, 0, 1, 0, 3);
        tbl[10] = mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        #4;
        tick();
        drive(1'b0, 1'b1, 3, 1'b1, 1'b1);
        #4;
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst_n, tbl[i].st, tbl[i].nv, tbl[i].cfg, tbl[i].iv);
            #4;
            chk_out($sformatf("table%0d", i), tbl[i].rdy, tbl[i].bsy, tbl[i].dn,
                    tbl[i].em, tbl[i].fst, 1'b0, 1'b0, tbl[i].tap, 0);
            tick();
        end

        run_batch(2, 1'b0, 2);
        run_batch(1, 1'b1, 1);
        for (int b = 0; b < 10; b++) begin
            run_batch(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 0);
        end

        // abort a batch with a one-cycle reset at accept 7
        drive(1'b1, 1'b1, 1, 1'b0, 1'b1);
        #4;
        tick();
        for (int c = 1; c <= 8; c++) begin
            drive((c == 8) ? 1'b0 : 1'b1, 1'b0, 0, 1'b0, 1'b1);
            #4;
            chk($sformatf("abort_c%0d.tap_index", c), 32'(tap_index), 32'(c - 1));
            chk($sformatf("abort_c%0d.first", c), 32'(first), 32'(c == 1));
            tick();
        end
        for (int c = 9; c <= 40; c++) begin
            drive(1'b1, 1'b0, 0, 1'b0, 1'b1);
            #4;
            chk_out($sformatf("abort_c%0d", c), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        ba_prev = 0;
        em_prev = 1'b0;
        run_batch(1, 1'b0, 2);
        run_batch(3, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
